// File: rtl/mem_stage_pkg.sv
// Memory-access definitions shared by the decoder and the MEM stage:
// MemOp encodings plus helpers that decode access size.
package mem_stage_pkg;

  localparam logic [2:0] MEMOP_W  = 3'd0;
  localparam logic [2:0] MEMOP_H  = 3'd1;
  localparam logic [2:0] MEMOP_HU = 3'd2;
  localparam logic [2:0] MEMOP_B  = 3'd3;
  localparam logic [2:0] MEMOP_BU = 3'd4;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } mem_size_e;

  // Codes 5-7 are not assigned and fall back to a word access.
  function automatic mem_size_e memop_size(input logic [2:0] op);
    mem_size_e sz;
    case (op)
      MEMOP_H, MEMOP_HU: sz = SZ_HALF;
      MEMOP_B, MEMOP_BU: sz = SZ_BYTE;
      default:           sz = SZ_WORD;
    endcase
    return sz;
  endfunction

  function automatic logic [3:0] byte_enable(input mem_size_e sz, input logic [1:0] lane);
    logic [3:0] be;
    case (sz)
      SZ_HALF: be = 4'b0011 << lane;
      SZ_BYTE: be = 4'b0001 << lane;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_stage_dm_ram.sv
// Data memory: asynchronous read, byte-enabled synchronous write,
// whole-array asynchronous clear on reset.
module dm_ram #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // A write coinciding with reset is dropped; the clear always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: address checking, store lane steering, load extraction
// and extension, and the M->W pipeline register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DM_WORDS = 1024,
  parameter int DM_AW    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegWrite_in,
  input  logic        MemWrite_in,
  input  logic        MemToReg_in,
  input  logic [2:0]  MemOp_in,
  input  logic [31:0] ALUOut_in,
  input  logic [31:0] WriteData_in,
  input  logic [4:0]  RegAddr_in,
  input  logic [31:0] pc_in,
  output logic        RegWrite_out,
  output logic [4:0]  RegAddr_out,
  output logic [31:0] RegData_out,
  output logic [31:0] pc_out,
  output logic        AddrErr_out
);

  mem_size_e        size;
  logic [1:0]       lane;
  logic [DM_AW-1:0] index;
  logic             mem_access;
  logic             misaligned;
  logic             out_of_range;
  logic             err;
  logic [3:0]       be;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic [31:0]      rshift;
  logic [31:0]      load_ext;

  assign size  = memop_size(MemOp_in);
  assign lane  = ALUOut_in[1:0];
  assign index = ALUOut_in[DM_AW+1:2];

  assign mem_access   = MemWrite_in | MemToReg_in;
  assign out_of_range = |ALUOut_in[31:DM_AW+2];

  always_comb begin
    misaligned = 1'b0;
    case (size)
      SZ_WORD: misaligned = |lane;
      SZ_HALF: misaligned = lane[0];
      default: misaligned = 1'b0;
    endcase
  end

  assign err = mem_access & (misaligned | out_of_range);

  // Replicated store data lets the byte enables alone select the lane.
  always_comb begin
    wdata = WriteData_in;
    case (size)
      SZ_HALF: wdata = {2{WriteData_in[15:0]}};
      SZ_BYTE: wdata = {4{WriteData_in[7:0]}};
      default: wdata = WriteData_in;
    endcase
  end

  assign be = byte_enable(size, lane);

  dm_ram #(
    .WORDS (DM_WORDS),
    .AW    (DM_AW)
  ) u_dm_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (index),
    .we    (MemWrite_in & ~err),
    .be    (be),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign rshift = rdata >> {lane, 3'b000};

  always_comb begin
    load_ext = rdata;
    case (MemOp_in)
      MEMOP_H:  load_ext = {{16{rshift[15]}}, rshift[15:0]};
      MEMOP_HU: load_ext = {16'h0000, rshift[15:0]};
      MEMOP_B:  load_ext = {{24{rshift[7]}}, rshift[7:0]};
      MEMOP_BU: load_ext = {24'h000000, rshift[7:0]};
      default:  load_ext = rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite_out <= 1'b0;
      RegAddr_out  <= '0;
      RegData_out  <= '0;
      pc_out       <= '0;
      AddrErr_out  <= 1'b0;
    end else begin
      RegWrite_out <= RegWrite_in & ~err;
      RegAddr_out  <= RegAddr_in;
      RegData_out  <= MemToReg_in ? load_ext : ALUOut_in;
      pc_out       <= pc_in;
      AddrErr_out  <= err;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage: the driver queues expected M->W
// contents per instruction, a monitor pops and compares one cycle later.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWrite_in, MemWrite_in, MemToReg_in;
  logic [2:0]  MemOp_in;
  logic [31:0] ALUOut_in, WriteData_in, pc_in;
  logic [4:0]  RegAddr_in;
  logic        RegWrite_out, AddrErr_out;
  logic [4:0]  RegAddr_out;
  logic [31:0] RegData_out, pc_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw;
    logic [4:0]  ra;
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
    logic        chk_data;
  } exp_t;

  exp_t        sb[$];
  logic        issued = 1'b0;
  logic [31:0] pc_cnt = 32'h100;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .RegWrite_in  (RegWrite_in),
    .MemWrite_in  (MemWrite_in),
    .MemToReg_in  (MemToReg_in),
    .MemOp_in     (MemOp_in),
    .ALUOut_in    (ALUOut_in),
    .WriteData_in (WriteData_in),
    .RegAddr_in   (RegAddr_in),
    .pc_in        (pc_in),
    .RegWrite_out (RegWrite_out),
    .RegAddr_out  (RegAddr_out),
    .RegData_out  (RegData_out),
    .pc_out       (pc_out),
    .AddrErr_out  (AddrErr_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bubble();
    RegWrite_in  = 1'b0;
    MemWrite_in  = 1'b0;
    MemToReg_in  = 1'b0;
    MemOp_in     = 3'd0;
    ALUOut_in    = '0;
    WriteData_in = '0;
    RegAddr_in   = '0;
    pc_in        = '0;
  endtask

  // exp_data is the hand-computed write-back value; chk_data=0 skips it
  // for rejected loads, whose data is never written back.
  task automatic issue(input logic rw, input logic mw, input logic mtr,
                       input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input logic [31:0] exp_data, input logic exp_err,
                       input logic chk_data);
    exp_t e;
    @(negedge clk);
    RegWrite_in  = rw;
    MemWrite_in  = mw;
    MemToReg_in  = mtr;
    MemOp_in     = op;
    ALUOut_in    = addr;
    WriteData_in = wd;
    RegAddr_in   = rd;
    pc_cnt       = pc_cnt + 32'd4;
    pc_in        = pc_cnt;
    e.rw       = rw & ~exp_err;
    e.ra       = rd;
    e.data     = exp_data;
    e.pc       = pc_cnt;
    e.err      = exp_err;
    e.chk_data = chk_data;
    sb.push_back(e);
    issued = 1'b1;
  endtask

  // Monitor: an instruction captured at a rising edge is visible at W just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (issued) begin
        #1;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: output presented with empty queue at pc_out %h", pc_out);
        end else begin
          e = sb.pop_front();
          chk($sformatf("RegWrite_out pc=%h", e.pc), {31'b0, RegWrite_out}, {31'b0, e.rw});
          chk($sformatf("RegAddr_out pc=%h", e.pc), {27'b0, RegAddr_out}, {27'b0, e.ra});
          chk($sformatf("pc_out pc=%h", e.pc), pc_out, e.pc);
          chk($sformatf("AddrErr_out pc=%h", e.pc), {31'b0, AddrErr_out}, {31'b0, e.err});
          if (e.chk_data) chk($sformatf("RegData_out pc=%h", e.pc), RegData_out, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bubble();
    repeat (2) @(negedge clk);
    chk("reset RegWrite_out", {31'b0, RegWrite_out}, 32'd0);
    chk("reset RegData_out", RegData_out, 32'd0);
    chk("reset pc_out", pc_out, 32'd0);
    chk("reset AddrErr_out", {31'b0, AddrErr_out}, 32'd0);
    rst_n = 1'b1;

    //     rw mw mtr op    addr          wd            rd  exp_data      err chk
    issue(0, 1, 0, 3'd0, 32'h10,       32'h12345678, 0, 32'h10,       0, 1); // SW
    issue(1, 0, 1, 3'd0, 32'h10,       32'h0,        1, 32'h12345678, 0, 1); // LW
    issue(0, 1, 0, 3'd3, 32'h11,       32'hFFFFFFAB, 0, 32'h11,       0, 1); // SB
    issue(1, 0, 1, 3'd0, 32'h10,       32'h0,        2, 32'h1234AB78, 0, 1);
    issue(1, 0, 1, 3'd3, 32'h11,       32'h0,        3, 32'hFFFFFFAB, 0, 1); // LB
    issue(1, 0, 1, 3'd4, 32'h11,       32'h0,        4, 32'h000000AB, 0, 1); // LBU
    issue(0, 1, 0, 3'd1, 32'h12,       32'h00008001, 0, 32'h12,       0, 1); // SH
    issue(1, 0, 1, 3'd1, 32'h12,       32'h0,        5, 32'hFFFF8001, 0, 1); // LH
    issue(1, 0, 1, 3'd2, 32'h12,       32'h0,        6, 32'h00008001, 0, 1); // LHU
    issue(1, 0, 1, 3'd0, 32'h10,       32'h0,        7, 32'h8001AB78, 0, 1);
    issue(1, 0, 1, 3'd0, 32'h13,       32'h0,        8, 32'h0,        1, 0); // misaligned LW
    issue(0, 1, 0, 3'd1, 32'h11,       32'h00001111, 0, 32'h11,       1, 1); // misaligned SH
    issue(1, 0, 1, 3'd0, 32'h10,       32'h0,        9, 32'h8001AB78, 0, 1); // unchanged
    issue(0, 1, 0, 3'd0, 32'h1000,     32'hFFFFFFFF, 0, 32'h1000,     1, 1); // out of range SW
    issue(1, 0, 1, 3'd0, 32'h0,        32'h0,       10, 32'h0,        0, 1); // no aliasing
    issue(1, 0, 1, 3'd0, 32'h1010,     32'h0,       11, 32'h0,        1, 0); // out of range LW
    issue(1, 0, 0, 3'd0, 32'hDEADBEEF, 32'h0,        5, 32'hDEADBEEF, 0, 1); // ALU op
    issue(0, 1, 0, 3'd3, 32'h17,       32'h123456CD, 0, 32'h17,       0, 1); // SB lane 3
    issue(0, 1, 0, 3'd4, 32'h14,       32'h00000077, 0, 32'h14,       0, 1); // store code 4 -> byte
    issue(1, 0, 1, 3'd0, 32'h14,       32'h0,       12, 32'hCD000077, 0, 1);
    issue(1, 0, 1, 3'd3, 32'h17,       32'h0,       13, 32'hFFFFFFCD, 0, 1);
    issue(0, 1, 0, 3'd2, 32'h16,       32'h0000BEEF, 0, 32'h16,       0, 1); // store code 2 -> half
    issue(1, 0, 1, 3'd0, 32'h14,       32'h0,       14, 32'hBEEF0077, 0, 1);
    issue(1, 0, 1, 3'd7, 32'h10,       32'h0,       15, 32'h8001AB78, 0, 1); // code 7 = word
    issue(1, 0, 1, 3'd7, 32'h12,       32'h0,       16, 32'h0,        1, 0); // code 7 misaligned
    issue(1, 0, 1, 3'd1, 32'h16,       32'h0,       17, 32'hFFFFBEEF, 0, 1); // LH upper half
    issue(0, 1, 0, 3'd0, 32'h20,       32'h0000ABCD, 0, 32'h20,       0, 1);
    issue(1, 0, 0, 3'd0, 32'hCAFEF00D, 32'h0,        7, 32'hCAFEF00D, 0, 1);

    // SW in flight, reset pulsed low between edges.
    @(negedge clk);
    issued       = 1'b0;
    RegWrite_in  = 1'b0;
    MemWrite_in  = 1'b1;
    MemToReg_in  = 1'b0;
    MemOp_in     = 3'd0;
    ALUOut_in    = 32'h24;
    WriteData_in = 32'h55555555;
    RegAddr_in   = 5'd0;
    pc_in        = 32'h900;
    #2 rst_n = 1'b0;
    #1;
    chk("async reset RegWrite_out", {31'b0, RegWrite_out}, 32'd0);
    chk("async reset RegAddr_out", {27'b0, RegAddr_out}, 32'd0);
    chk("async reset RegData_out", RegData_out, 32'd0);
    chk("async reset pc_out", pc_out, 32'd0);
    chk("async reset AddrErr_out", {31'b0, AddrErr_out}, 32'd0);
    bubble();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue(1, 0, 1, 3'd0, 32'h24,       32'h0,       18, 32'h0,        0, 1); // store discarded
    issue(1, 0, 1, 3'd0, 32'h20,       32'h0,       19, 32'h0,        0, 1); // array cleared
    issue(1, 0, 1, 3'd0, 32'h10,       32'h0,       20, 32'h0,        0, 1);

    @(negedge clk);
    issued = 1'b0;
    bubble();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
